// File: rtl/s_to_p_gearbox.sv
// Serial-to-parallel gearbox: packs IN_W-bit beats into OUT_BEATS-beat words,
// with valid/ready on both sides, selectable slot order and partial-word flush.
module s_to_p_gearbox #(
    parameter int IN_W      = 1,
    parameter int OUT_BEATS = 6,
    parameter int MSB_FIRST = 0,
    localparam int OUT_W    = IN_W * OUT_BEATS,
    localparam int CW       = $clog2(OUT_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_a,
    input  logic [IN_W-1:0]  data_a,
    output logic             ready_a,
    input  logic             flush,
    output logic             valid_b,
    input  logic             ready_b,
    output logic [OUT_W-1:0] data_b,
    output logic [CW-1:0]    cnt_b
);

    localparam logic [CW-1:0] LAST = CW'(OUT_BEATS - 1);
    localparam logic [CW-1:0] FULL = CW'(OUT_BEATS);
    localparam logic [CW-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        FILL,
        PEND
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]    beat_cnt, cnt_w, cnt_nx;
    logic [CW-1:0]    slot;
    logic [OUT_W-1:0] acc, acc_w, acc_nx;
    logic             out_free;
    logic             take;
    logic             load;
    logic [OUT_W-1:0] load_data;
    logic [CW-1:0]    load_cnt;

    assign out_free = !valid_b || ready_b;
    assign ready_a  = (state != INIT) && (state != PEND)
                   && (beat_cnt != LAST || out_free);
    assign take     = valid_a && ready_a;
    assign slot     = (MSB_FIRST != 0) ? (LAST - beat_cnt) : beat_cnt;
    assign cnt_w    = beat_cnt + {{(CW-1){1'b0}}, take};

    // Accumulator view including the beat taken this cycle.
    always_comb begin
        acc_w = acc;
        if (take) begin
            acc_w[slot*IN_W +: IN_W] = data_a;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt_w;
        acc_nx    = acc_w;
        load      = 1'b0;
        load_data = acc_w;
        load_cnt  = cnt_w;
        unique case (state)
            INIT: begin
                state_nx = IDLE;
                cnt_nx   = ZERO;
                acc_nx   = '0;
            end
            PEND: begin
                // No beats are taken here, so acc/beat_cnt are the flushed word.
                if (out_free) begin
                    load      = 1'b1;
                    load_data = acc;
                    load_cnt  = beat_cnt;
                    cnt_nx    = ZERO;
                    acc_nx    = '0;
                    state_nx  = IDLE;
                end
            end
            IDLE, FILL: begin
                if (cnt_w == FULL) begin
                    load     = 1'b1;
                    cnt_nx   = ZERO;
                    acc_nx   = '0;
                    state_nx = IDLE;
                end else if (flush && cnt_w != ZERO) begin
                    if (out_free) begin
                        load     = 1'b1;
                        cnt_nx   = ZERO;
                        acc_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        state_nx = PEND;
                    end
                end else begin
                    state_nx = (cnt_w == ZERO) ? IDLE : FILL;
                end
            end
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            beat_cnt <= ZERO;
            acc      <= '0;
            valid_b  <= 1'b0;
            data_b   <= '0;
            cnt_b    <= ZERO;
        end else begin
            state    <= state_nx;
            beat_cnt <= cnt_nx;
            acc      <= acc_nx;
            if (load) begin
                valid_b <= 1'b1;
                data_b  <= load_data;
                cnt_b   <= load_cnt;
            end else if (ready_b) begin
                valid_b <= 1'b0;
            end
        end
    end

endmodule
